generador_frecuencia: RTL and testbench

//  Programmable square-wave generator: the transmit-side companion of the frequency meter.

---
 rtl/generador_pkg.sv | 17 +
 rtl/generador_frecuencia_if.sv | 15 +
 rtl/div_secuencial.sv | 76 +++++++
 rtl/generador_frecuencia.sv | 145 ++++++++++++++
 tb/tb_generador_frecuencia.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/generador_pkg.sv
// Shared constants, FSM state type and divider sizing helper for the square-wave generator.
package generador_pkg;

  localparam int unsigned FwDefault    = 28;
  localparam int unsigned ClkHzDefault = 100_000_000;

  typedef enum logic [1:0] {
    StIdle,
    StDivide,
    StPending
  } gen_state_e;

  function automatic int unsigned div_cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/generador_frecuencia_if.sv
// Frequency configuration port: valid/ready handshake carrying the requested frequency in Hz.
interface generador_frecuencia_if
  import generador_pkg::*;
#(
  parameter int unsigned FW = FwDefault
) ();

  logic          cfg_valid;
  logic          cfg_ready;
  logic [FW-1:0] freq_in;

  modport master (output cfg_valid, output freq_in, input cfg_ready);
  modport slave  (input cfg_valid, input freq_in, output cfg_ready);

endinterface

// File: rtl/div_secuencial.sv
// Restoring divider, one quotient bit per cycle over FW cycles; done pulses during the final step
// with the finished quotient on quotient_o.
module div_secuencial
  import generador_pkg::*;
#(
  parameter int unsigned FW = FwDefault
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [FW-1:0] dividend_i,
  input  logic [FW:0]   divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [FW-1:0] quotient_o
);

  localparam int unsigned CntW = div_cnt_width(FW);

  logic            busy_q, busy_d;
  logic [CntW-1:0] step_q, step_d;
  logic [FW-1:0]   dvd_q, dvd_d;
  logic [FW:0]     rem_q, rem_d;
  logic [FW:0]     dsr_q, dsr_d;
  logic [FW+1:0]   rem_sh;
  logic [FW:0]     rem_sub;
  logic            fits;

  // Quotient bits shift into the low end of the dividend register as it empties.
  always_comb begin
    rem_sh     = {rem_q, dvd_q[FW-1]};
    fits       = rem_sh >= {1'b0, dsr_q};
    rem_sub    = rem_sh[FW:0] - dsr_q;
    quotient_o = {dvd_q[FW-2:0], fits};
    done_o     = busy_q && (step_q == CntW'(FW - 1));

    busy_d = busy_q;
    step_d = step_q;
    dvd_d  = dvd_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    if (start_i && !busy_q) begin
      busy_d = 1'b1;
      step_d = '0;
      dvd_d  = dividend_i;
      dsr_d  = divisor_i;
      rem_d  = '0;
    end else if (busy_q) begin
      rem_d  = fits ? rem_sub : rem_sh[FW:0];
      dvd_d  = quotient_o;
      step_d = step_q + 1'b1;
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      step_q <= '0;
      dvd_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      step_q <= step_d;
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/generador_frecuencia.sv
// Programmable 50% square-wave generator: converts a requested frequency into a half period and
// swaps it in only at the end of a low half so no period is ever truncated.
module generador_frecuencia
  import generador_pkg::*;
#(
  parameter int unsigned CLK_HZ = ClkHzDefault,
  parameter int unsigned FW     = FwDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  generador_frecuencia_if.slave  cfg,
  output logic                   wave_out_o,
  output logic                   period_tick_o,
  output logic                   active_o,
  output logic                   freq_err_o
);

  localparam logic [FW:0]   HalfClk  = (FW + 1)'(CLK_HZ / 2);
  localparam logic [FW-1:0] Dividend = FW'(CLK_HZ);

  gen_state_e    state_q, state_d;
  logic [FW-1:0] freq_q, freq_d;
  logic [FW-1:0] new_half_q, new_half_d;
  logic [FW-1:0] half_per_q, half_per_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          wave_q, wave_d;
  logic          tick_q, tick_d;
  logic          run_q, run_d;

  logic          div_start, div_busy, div_done;
  logic [FW-1:0] quotient;
  logic          active, low_end, apply;

  div_secuencial #(
    .FW (FW)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (Dividend),
    .divisor_i  ({cfg.freq_in, 1'b0}),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  assign cfg.cfg_ready = (state_q == StIdle) && !div_busy;
  assign active        = (half_per_q != '0) && enable_i;
  assign low_end       = active && !wave_q && (cnt_q == half_per_q - FW'(1));

  always_comb begin
    state_d    = state_q;
    freq_d     = freq_q;
    new_half_d = new_half_q;
    err_d      = err_q;
    div_start  = 1'b0;
    apply      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg.cfg_valid && cfg.cfg_ready) begin
          freq_d = cfg.freq_in;
          err_d  = 1'b0;
          if (cfg.freq_in == '0) begin
            new_half_d = '0;
            state_d    = StPending;
          end else begin
            div_start = 1'b1;
            state_d   = StDivide;
          end
        end
      end
      StDivide: begin
        if (div_done) begin
          new_half_d = (quotient == '0) ? FW'(1) : quotient;
          err_d      = {1'b0, freq_q} > HalfClk;
          state_d    = StPending;
        end
      end
      StPending: begin
        if (!active || low_end) begin
          apply   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A stopped generator (run_q=0) starts with an immediate rising edge.
  always_comb begin
    half_per_d = apply ? new_half_q : half_per_q;
    wave_d     = wave_q;
    cnt_d      = cnt_q;
    tick_d     = 1'b0;
    run_d      = run_q;
    if (!enable_i || half_per_d == '0) begin
      wave_d = 1'b0;
      cnt_d  = '0;
      run_d  = 1'b0;
    end else if (!run_q) begin
      wave_d = 1'b1;
      cnt_d  = '0;
      tick_d = 1'b1;
      run_d  = 1'b1;
    end else if (cnt_q == half_per_q - FW'(1)) begin
      cnt_d  = '0;
      wave_d = !wave_q;
      tick_d = !wave_q;
    end else begin
      cnt_d = cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      freq_q     <= '0;
      new_half_q <= '0;
      half_per_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      wave_q     <= 1'b0;
      tick_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      new_half_q <= new_half_d;
      half_per_q <= half_per_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      wave_q     <= wave_d;
      tick_q     <= tick_d;
      run_q      <= run_d;
    end
  end

  assign wave_out_o    = wave_q;
  assign period_tick_o = tick_q;
  assign active_o      = active;
  assign freq_err_o    = err_q;

endmodule

// File: tb/tb_generador_frecuencia.sv
// Self-checking bench for generador_frecuencia at CLK_HZ=1000; half-period lengths are queued
// when a frequency is requested and compared as the wave is observed.
module tb_generador_frecuencia;

  localparam int unsigned ClkHz = 1000;
  localparam int unsigned Fw    = 28;
  localparam int unsigned Limit = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic wave, tick, active, ferr;

  generador_frecuencia_if #(.FW(Fw)) cfg_if ();

  generador_frecuencia #(
    .CLK_HZ (ClkHz),
    .FW     (Fw)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable),
    .cfg           (cfg_if),
    .wave_out_o    (wave),
    .period_tick_o (tick),
    .active_o      (active),
    .freq_err_o    (ferr)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [Fw-1:0] f);
    int unsigned n = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.freq_in   = f;
    while (!cfg_if.cfg_ready && n < Limit) begin
      step();
      n++;
    end
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int unsigned n = 0;
    while (!cfg_if.cfg_ready && n < Limit) begin
      step();
      n++;
    end
    check_eq({tag, "_ready_bound"}, n < Limit, 1);
  endtask

  task automatic wait_rise(input string tag);
    int unsigned n = 0;
    while (!tick && n < Limit) begin
      step();
      n++;
    end
    check_eq({tag, "_rise_bound"}, n < Limit, 1);
  endtask

  // Starts on a cycle where wave has just risen; ends on the next rise.
  task automatic measure_period(input string tag);
    int unsigned hi = 0;
    int unsigned lo = 0;
    int unsigned e_hi = 0;
    int unsigned e_lo = 0;
    while (wave === 1'b1 && hi < Limit) begin
      hi++;
      step();
    end
    while (wave === 1'b0 && lo < Limit) begin
      lo++;
      step();
    end
    check_eq({tag, "_tick"}, tick, 1);
    check_eq({tag, "_sb_depth"}, exp_q.size() >= 2, 1);
    if (exp_q.size() > 0) e_hi = exp_q.pop_front();
    if (exp_q.size() > 0) e_lo = exp_q.pop_front();
    check_eq({tag, "_high"}, hi, e_hi);
    check_eq({tag, "_low"}, lo, e_lo);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned ticks;
    int unsigned highs;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.freq_in   = '0;

    // Reset values, then reset during a divide drops the request.
    step();
    check_eq("rst_ready", cfg_if.cfg_ready, 1);
    check_eq("rst_wave", wave, 0);
    check_eq("rst_tick", tick, 0);
    check_eq("rst_active", active, 0);
    check_eq("rst_err", ferr, 0);
    rst = 1'b0;
    step();
    send(28'd10);
    repeat (5) step();
    check_eq("t1_busy", cfg_if.cfg_ready, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("t1_ready_async", cfg_if.cfg_ready, 1);
    check_eq("t1_wave", wave, 0);
    check_eq("t1_err", ferr, 0);
    step();
    rst = 1'b0;
    step();
    check_eq("t1_ready_next", cfg_if.cfg_ready, 1);
    enable = 1'b1;
    repeat (40) step();
    check_eq("t1_dropped_active", active, 0);
    check_eq("t1_dropped_wave", wave, 0);

    // 10 Hz from stopped.
    send(28'd10);
    n = 0;
    while (!cfg_if.cfg_ready && n < Limit) begin
      n++;
      step();
    end
    check_eq("t2_ready_low", n, 29);
    check_eq("t2_first_wave", wave, 1);
    check_eq("t2_first_tick", tick, 1);
    check_eq("t2_active", active, 1);
    exp_q.push_back(50); exp_q.push_back(50);
    exp_q.push_back(50); exp_q.push_back(50);
    measure_period("t2_p0");
    measure_period("t2_p1");

    // Retune to 25 Hz in the middle of a high half.
    exp_q.push_back(50); exp_q.push_back(50);
    exp_q.push_back(20); exp_q.push_back(20);
    exp_q.push_back(20); exp_q.push_back(20);
    fork
      begin
        for (int i = 0; i < 3; i++) measure_period($sformatf("t3_p%0d", i));
      end
      begin
        repeat (10) step();
        send(28'd25);
      end
    join

    // 500 Hz -> H=1.
    exp_q.push_back(20); exp_q.push_back(20);
    exp_q.push_back(1);  exp_q.push_back(1);
    exp_q.push_back(1);  exp_q.push_back(1);
    fork
      begin
        for (int i = 0; i < 3; i++) measure_period($sformatf("t4_p%0d", i));
      end
      begin
        send(28'd500);
      end
    join
    check_eq("t4_err_500", ferr, 0);

    // 700 Hz clamps to H=1 with error flag; next request clears it.
    send(28'd700);
    wait_ready("t4_700");
    check_eq("t4_err_700", ferr, 1);
    wait_rise("t4_700");
    exp_q.push_back(1); exp_q.push_back(1);
    exp_q.push_back(1); exp_q.push_back(1);
    measure_period("t4_700_p0");
    measure_period("t4_700_p1");
    send(28'd25);
    check_eq("t4_err_cleared", ferr, 0);
    wait_ready("t4_25");
    wait_rise("t4_25");
    exp_q.push_back(20); exp_q.push_back(20);
    measure_period("t4_25_p0");

    // Stop: applies after the current low half.
    send(28'd0);
    n = 1;
    while (!cfg_if.cfg_ready && n < Limit) begin
      n++;
      step();
    end
    check_eq("t5_stop_latency", n, 40);
    check_eq("t5_active", active, 0);
    check_eq("t5_wave", wave, 0);
    ticks = 0;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tick) ticks++;
      if (wave) highs++;
    end
    check_eq("t5_no_ticks", ticks, 0);
    check_eq("t5_no_high", highs, 0);

    // Enable dropout mid-high at 10 Hz.
    send(28'd10);
    wait_ready("t6");
    wait_rise("t6");
    repeat (10) step();
    check_eq("t6_pre_wave", wave, 1);
    enable = 1'b0;
    step();
    check_eq("t6_off_wave", wave, 0);
    check_eq("t6_off_active", active, 0);
    check_eq("t6_off_tick", tick, 0);
    step();
    check_eq("t6_off_wave2", wave, 0);
    step();
    check_eq("t6_off_wave3", wave, 0);
    enable = 1'b1;
    step();
    check_eq("t6_re_wave", wave, 1);
    check_eq("t6_re_tick", tick, 1);
    exp_q.push_back(50); exp_q.push_back(50);
    exp_q.push_back(50); exp_q.push_back(50);
    measure_period("t6_p0");
    measure_period("t6_p1");
    check_eq("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
